// File: rtl/inverse_substitution_box_generator.sv
// ============================================================================
// inverse_substitution_box_generator
//
// Builds the 256-entry inverse substitution table used on the decryption path
// from the forward table handed over by the forward generator. The forward
// table is captured once into a private snapshot. The snapshot is then walked
// one entry per enabled cycle, writing inv[sbox[i]] = i. When duplicate
// checking is enabled, the walk stops on the first forward value that has
// already been seen, because such a table has no inverse.
//
// A registered single-byte lookup port exposes the finished table. It returns
// zero whenever the table is not complete.
//
// Parameters
//   CHECK_BIJECTIVE  1: a repeated forward value raises error and stops the walk
//                    0: a repeated forward value overwrites silently; error and
//                       error_index stay zero
//
// Ports
//   clk            in   1     system clock, rising edge
//   reset          in   1     synchronous, active-high
//   enable_bar     in   1     active-low enable; high pauses the walk
//   sbox_flat      in   2048  forward table, entry i at bits 8*i+7 : 8*i
//   sbox_ready     in   1     forward table valid
//   inv_sbox_flat  out  2048  inverse table, same packing as sbox_flat
//   ready          out  1     inverse table complete and valid
//   error          out  1     forward table is not a permutation
//   error_index    out  8     forward index whose value was already seen
//   lookup_in      in   8     byte to inverse-substitute
//   lookup_out     out  8     registered inv[lookup_in], zero while not ready
// ============================================================================
module inverse_substitution_box_generator #(
    parameter int CHECK_BIJECTIVE = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable_bar,
    input  logic [2047:0] sbox_flat,
    input  logic          sbox_ready,
    output logic [2047:0] inv_sbox_flat,
    output logic          ready,
    output logic          error,
    output logic [7:0]    error_index,
    input  logic [7:0]    lookup_in,
    output logic [7:0]    lookup_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam bit CHECK_EN = (CHECK_BIJECTIVE != 0);

    state_t        state;
    state_t        state_next;

    logic [2047:0] snap;
    logic [2047:0] inv;
    logic [255:0]  seen;
    logic [7:0]    idx;
    logic [7:0]    cur_byte;

    logic          start;
    logic          step;
    logic          dup;

    // The forward value being processed this cycle. Every row is 8 bits wide,
    // so {idx, 3'b000} is the bit offset of entry idx in the 2048-bit vector.
    assign cur_byte = snap[{idx, 3'b000} +: 8];

    // A repeated forward value only counts as a fault when checking is enabled.
    // Otherwise, the later index simply overwrites the earlier one.
    assign dup   = CHECK_EN && seen[cur_byte];
    assign start = (state == IDLE)  && sbox_ready && !enable_bar;
    assign step  = (state == BUILD) && !enable_bar;

    assign ready         = (state == DONE);
    assign error         = CHECK_EN && (state == ERROR);
    assign inv_sbox_flat = inv;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Leaving DONE or ERROR requires sbox_ready to drop.
    // A held-high sbox_ready therefore cannot restart a build on its own.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = BUILD;
                end
            end
            BUILD: begin
                if (step) begin
                    if (dup) begin
                        state_next = ERROR;
                    end else if (idx == 8'hFF) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (!sbox_ready) begin
                    state_next = IDLE;
                end
            end
            ERROR: begin
                if (!sbox_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Table datapath.
    // A build starts by capturing the forward table, so any later changes on
    // sbox_flat cannot disturb a walk that is already in progress. The
    // previous inverse table stays visible after DONE. It is only cleared
    // when the next build starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap        <= '0;
            inv         <= '0;
            seen        <= '0;
            idx         <= 8'h00;
            error_index <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        snap        <= sbox_flat;
                        inv         <= '0;
                        seen        <= '0;
                        idx         <= 8'h00;
                        error_index <= 8'h00;
                    end
                end
                BUILD: begin
                    if (step) begin
                        if (dup) begin
                            error_index <= idx;
                        end else begin
                            inv[{cur_byte, 3'b000} +: 8] <= idx;
                            seen[cur_byte]               <= 1'b1;
                            if (idx != 8'hFF) begin
                                idx <= idx + 8'd1;
                            end
                        end
                    end
                end
                ERROR: begin
                    if (!sbox_ready) begin
                        error_index <= 8'h00;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered lookup. The table is only exposed once it is complete.
    always_ff @(posedge clk) begin
        if (reset) begin
            lookup_out <= 8'h00;
        end else begin
            lookup_out <= ready ? inv[{lookup_in, 3'b000} +: 8] : 8'h00;
        end
    end

endmodule

// File: tb/tb_inverse_substitution_box_generator.sv
// ============================================================================
// tb_inverse_substitution_box_generator
//
// Directed bench for inverse_substitution_box_generator. Each scenario task
// drives its own stimulus and compares outputs against hand-derived values:
// identity, AES forward table, duplicate detection, pause, mid-build reset,
// and snapshot isolation.
// ============================================================================
module tb_inverse_substitution_box_generator;

    logic          clk;
    logic          reset;
    logic          enable_bar;
    logic [2047:0] sbox_flat;
    logic          sbox_ready;
    logic [2047:0] inv_sbox_flat;
    logic          ready;
    logic          error;
    logic [7:0]    error_index;
    logic [7:0]    lookup_in;
    logic [7:0]    lookup_out;

    int vectors;
    int miscompares;

    inverse_substitution_box_generator #(
        .CHECK_BIJECTIVE(1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable_bar    (enable_bar),
        .sbox_flat     (sbox_flat),
        .sbox_ready    (sbox_ready),
        .inv_sbox_flat (inv_sbox_flat),
        .ready         (ready),
        .error         (error),
        .error_index   (error_index),
        .lookup_in     (lookup_in),
        .lookup_out    (lookup_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // AES forward S-box, entry i at position i.
    logic [7:0] aes_fwd [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    // Table whose entry i is i ^ key (key 0 gives identity). Its inverse is
    // again j ^ key.
    function automatic logic [2047:0] make_xor(input logic [7:0] key);
        logic [2047:0] t;
        t = '0;
        for (int i = 0; i < 256; i++) begin
            t[8*i +: 8] = 8'(i) ^ key;
        end
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until ready rises or the limit expires. The limit value is
    // returned when ready never rose.
    task automatic count_to_ready(input int limit, output int cycles);
        cycles = 0;
        while (!ready && cycles < limit) begin
            tick();
            cycles++;
        end
    endtask

    task automatic leave_done();
        sbox_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        enable_bar = 1'b1;
        sbox_ready = 1'b0;
        sbox_flat  = '0;
        lookup_in  = 8'h00;
        tick();
        tick();
        vectors++;
        if (ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b expected 0", ready);
        end
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_error: got %b expected 0", error);
        end
        vectors++;
        if (error_index !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_error_index: got %h expected 00", error_index);
        end
        vectors++;
        if (lookup_out !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_lookup: got %h expected 00", lookup_out);
        end
        vectors++;
        if (inv_sbox_flat !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_table: table not all zero");
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_identity();
        int cyc;
        sbox_flat  = make_xor(8'h00);
        enable_bar = 1'b0;
        sbox_ready = 1'b1;
        count_to_ready(400, cyc);
        vectors++;
        if (cyc !== 257) begin
            miscompares++;
            $display("[TB] FAIL identity_latency: got %0d cycles expected 257", cyc);
        end
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL identity_error: got %b expected 0", error);
        end
        for (int j = 0; j < 256; j++) begin
            vectors++;
            if (inv_sbox_flat[8*j +: 8] !== 8'(j)) begin
                miscompares++;
                $display("[TB] FAIL identity_inv[%0d]: got %h expected %h",
                         j, inv_sbox_flat[8*j +: 8], 8'(j));
            end
        end
        // sbox_ready stays high: no retrigger, table stays put.
        for (int k = 0; k < 5; k++) tick();
        vectors++;
        if (ready !== 1'b1 || inv_sbox_flat[8*7 +: 8] !== 8'h07) begin
            miscompares++;
            $display("[TB] FAIL identity_hold: got ready=%b inv[7]=%h expected ready=1 inv[7]=07",
                     ready, inv_sbox_flat[8*7 +: 8]);
        end
        sbox_ready = 1'b0;
        tick();
        vectors++;
        if (ready !== 1'b0 || inv_sbox_flat[8*10 +: 8] !== 8'h0A) begin
            miscompares++;
            $display("[TB] FAIL identity_drop: got ready=%b inv[10]=%h expected ready=0 inv[10]=0a",
                     ready, inv_sbox_flat[8*10 +: 8]);
        end
        tick();
    endtask

    task automatic test_aes();
        int            cyc;
        logic [2047:0] fwd;
        logic [7:0]    exp_inv [256];
        for (int i = 0; i < 256; i++) begin
            fwd[8*i +: 8]      = aes_fwd[i];
            exp_inv[aes_fwd[i]] = 8'(i);
        end
        sbox_flat  = fwd;
        sbox_ready = 1'b1;
        count_to_ready(400, cyc);
        vectors++;
        if (cyc !== 257) begin
            miscompares++;
            $display("[TB] FAIL aes_latency: got %0d cycles expected 257", cyc);
        end
        vectors++;
        if (inv_sbox_flat[8*8'h63 +: 8] !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL aes_inv63: got %h expected 00", inv_sbox_flat[8*8'h63 +: 8]);
        end
        vectors++;
        if (inv_sbox_flat[8*8'h7C +: 8] !== 8'h01) begin
            miscompares++;
            $display("[TB] FAIL aes_inv7c: got %h expected 01", inv_sbox_flat[8*8'h7C +: 8]);
        end
        vectors++;
        if (inv_sbox_flat[8*8'h16 +: 8] !== 8'hFF) begin
            miscompares++;
            $display("[TB] FAIL aes_inv16: got %h expected ff", inv_sbox_flat[8*8'h16 +: 8]);
        end
        vectors++;
        if (inv_sbox_flat[8*8'h00 +: 8] !== 8'h52 || inv_sbox_flat[8*8'hF0 +: 8] !== 8'h17) begin
            miscompares++;
            $display("[TB] FAIL aes_inv00_f0: got %h/%h expected 52/17",
                     inv_sbox_flat[8*8'h00 +: 8], inv_sbox_flat[8*8'hF0 +: 8]);
        end
        for (int j = 0; j < 256; j++) begin
            vectors++;
            if (inv_sbox_flat[8*j +: 8] !== exp_inv[j]) begin
                miscompares++;
                $display("[TB] FAIL aes_inv[%0d]: got %h expected %h",
                         j, inv_sbox_flat[8*j +: 8], exp_inv[j]);
            end
        end
        lookup_in = 8'h63;
        tick();
        vectors++;
        if (lookup_out !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL aes_lookup63: got %h expected 00", lookup_out);
        end
        lookup_in = 8'h00;
        tick();
        vectors++;
        if (lookup_out !== 8'h52) begin
            miscompares++;
            $display("[TB] FAIL aes_lookup00: got %h expected 52", lookup_out);
        end
        leave_done();
    endtask

    task automatic test_duplicate();
        logic [2047:0] t;
        logic          saw_ready;
        int            cyc;
        t            = make_xor(8'h00);
        t[8*5 +: 8]  = 8'h03;
        sbox_flat    = t;
        sbox_ready   = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL dup_early: got error=%b expected 0 after edge 5", error);
        end
        tick();
        vectors++;
        if (error !== 1'b1 || error_index !== 8'h05) begin
            miscompares++;
            $display("[TB] FAIL dup_flag: got error=%b index=%h expected 1/05", error, error_index);
        end
        saw_ready = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (ready === 1'b1) saw_ready = 1'b1;
        end
        vectors++;
        if (saw_ready !== 1'b0 || error !== 1'b1 || error_index !== 8'h05) begin
            miscompares++;
            $display("[TB] FAIL dup_hold: got ready_seen=%b error=%b index=%h expected 0/1/05",
                     saw_ready, error, error_index);
        end
        sbox_ready = 1'b0;
        tick();
        vectors++;
        if (error !== 1'b0 || ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL dup_clear: got error=%b ready=%b expected 0/0", error, ready);
        end
        // Back in IDLE: a fresh build runs with the usual latency.
        sbox_flat  = make_xor(8'h00);
        sbox_ready = 1'b1;
        count_to_ready(400, cyc);
        vectors++;
        if (cyc !== 257) begin
            miscompares++;
            $display("[TB] FAIL dup_rebuild: got %0d cycles expected 257", cyc);
        end
        leave_done();
    endtask

    task automatic test_pause();
        int cyc;
        sbox_flat  = make_xor(8'h00);
        sbox_ready = 1'b1;
        for (int k = 0; k < 101; k++) tick();
        enable_bar = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        vectors++;
        if (inv_sbox_flat[8*100 +: 8] !== 8'h00 || inv_sbox_flat[8*99 +: 8] !== 8'd99 ||
            ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL pause_frozen: got inv[100]=%h inv[99]=%h ready=%b expected 00/63/0",
                     inv_sbox_flat[8*100 +: 8], inv_sbox_flat[8*99 +: 8], ready);
        end
        enable_bar = 1'b0;
        count_to_ready(400, cyc);
        vectors++;
        if (111 + cyc !== 267) begin
            miscompares++;
            $display("[TB] FAIL pause_latency: got %0d cycles expected 267", 111 + cyc);
        end
        for (int j = 0; j < 256; j++) begin
            vectors++;
            if (inv_sbox_flat[8*j +: 8] !== 8'(j)) begin
                miscompares++;
                $display("[TB] FAIL pause_inv[%0d]: got %h expected %h",
                         j, inv_sbox_flat[8*j +: 8], 8'(j));
            end
        end
        leave_done();
    endtask

    task automatic test_reset_mid();
        int cyc;
        sbox_flat  = make_xor(8'hFF);
        sbox_ready = 1'b1;
        lookup_in  = 8'h10;
        for (int k = 0; k < 129; k++) tick();
        reset = 1'b1;
        tick();
        vectors++;
        if (ready !== 1'b0 || error !== 1'b0 || lookup_out !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL midreset_flags: got ready=%b error=%b lookup=%h expected 0/0/00",
                     ready, error, lookup_out);
        end
        vectors++;
        if (inv_sbox_flat !== '0) begin
            miscompares++;
            $display("[TB] FAIL midreset_table: table not all zero");
        end
        reset      = 1'b0;
        sbox_ready = 1'b0;
        tick();
        sbox_ready = 1'b1;
        count_to_ready(400, cyc);
        vectors++;
        if (cyc !== 257) begin
            miscompares++;
            $display("[TB] FAIL midreset_latency: got %0d cycles expected 257", cyc);
        end
        for (int j = 0; j < 256; j++) begin
            vectors++;
            if (inv_sbox_flat[8*j +: 8] !== ~8'(j)) begin
                miscompares++;
                $display("[TB] FAIL midreset_inv[%0d]: got %h expected %h",
                         j, inv_sbox_flat[8*j +: 8], ~8'(j));
            end
        end
        leave_done();
    endtask

    task automatic test_snapshot();
        int         cyc;
        logic [7:0] probes [4] = '{8'h5A, 8'h00, 8'hFF, 8'h33};
        sbox_flat  = make_xor(8'h5A);
        sbox_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        for (int w = 0; w < 64; w++) begin
            sbox_flat[32*w +: 32] = $urandom();
        end
        for (int p = 0; p < 4; p++) begin
            lookup_in = probes[p];
            tick();
            vectors++;
            if (lookup_out !== 8'h00) begin
                miscompares++;
                $display("[TB] FAIL snap_lookup_busy[%0d]: got %h expected 00", p, lookup_out);
            end
        end
        count_to_ready(400, cyc);
        vectors++;
        if (7 + cyc !== 257) begin
            miscompares++;
            $display("[TB] FAIL snap_latency: got %0d cycles expected 257", 7 + cyc);
        end
        for (int j = 0; j < 256; j++) begin
            vectors++;
            if (inv_sbox_flat[8*j +: 8] !== (8'(j) ^ 8'h5A)) begin
                miscompares++;
                $display("[TB] FAIL snap_inv[%0d]: got %h expected %h",
                         j, inv_sbox_flat[8*j +: 8], 8'(j) ^ 8'h5A);
            end
        end
        lookup_in = 8'h5A;
        tick();
        vectors++;
        if (lookup_out !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL snap_lookup5a: got %h expected 00", lookup_out);
        end
        lookup_in = 8'h00;
        tick();
        vectors++;
        if (lookup_out !== 8'h5A) begin
            miscompares++;
            $display("[TB] FAIL snap_lookup00: got %h expected 5a", lookup_out);
        end
        leave_done();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_identity();
        test_aes();
        test_duplicate();
        test_pause();
        test_reset_mid();
        test_snapshot();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
